// File: rtl/regfile_fwd_pkg.sv
// Shared types and constants for the register file and its bypass network.
// Imported by the interface, the forwarding mux and the top.
package regfile_fwd_pkg;

    localparam int RegNum   = 32;
    localparam int RegAddrW = $clog2(RegNum);
    localparam int RegDataW = 32;

    typedef logic [RegAddrW-1:0] RegAddrBus;
    typedef logic [RegDataW-1:0] RegBus;

    localparam RegBus     ZeroWord     = '0;
    localparam RegAddrBus NOPRegAddr   = '0;
    localparam logic      WriteEnable  = 1'b1;
    localparam logic      WriteDisable = 1'b0;
    localparam logic      ReadEnable   = 1'b1;
    localparam logic      ReadDisable  = 1'b0;

    // Where a read port takes its value from, youngest producer first.
    typedef enum logic [2:0] {
        SRC_ZERO,
        SRC_EX,
        SRC_MEM,
        SRC_WB,
        SRC_ARR
    } fwd_src_e;

endpackage

// File: rtl/regfile_fwd_if.sv
// Bundle of write-back, bypass and read-port signals around the register file.
// The pipeline drives through master; the register file sits on slave.
interface regfile_fwd_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          ex_wreg;
    logic [AW-1:0] ex_wd;
    logic [DW-1:0] ex_wdata;
    logic          mem_wreg;
    logic [AW-1:0] mem_wd;
    logic [DW-1:0] mem_wdata;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          re1;
    logic [AW-1:0] raddr1;
    logic [DW-1:0] rdata1;
    logic          re2;
    logic [AW-1:0] raddr2;
    logic [DW-1:0] rdata2;
    logic          hilo_we;
    logic [DW-1:0] hi_i;
    logic [DW-1:0] lo_i;
    logic [DW-1:0] hi_o;
    logic [DW-1:0] lo_o;

    modport master (
        output ex_wreg, ex_wd, ex_wdata,
        output mem_wreg, mem_wd, mem_wdata,
        output we, waddr, wdata,
        output re1, raddr1, re2, raddr2,
        output hilo_we, hi_i, lo_i,
        input  rdata1, rdata2, hi_o, lo_o
    );

    modport slave (
        input  ex_wreg, ex_wd, ex_wdata,
        input  mem_wreg, mem_wd, mem_wdata,
        input  we, waddr, wdata,
        input  re1, raddr1, re2, raddr2,
        input  hilo_we, hi_i, lo_i,
        output rdata1, rdata2, hi_o, lo_o
    );

endinterface

// File: rtl/regfile_fwd_mux.sv
// Per-port read selector: reset, disable, r0, then EX > MEM > WB > array.
// Fully combinational; one instance per read port.
module regfile_fwd_mux
    import regfile_fwd_pkg::*;
#(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          rst,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    input  logic          ex_wreg,
    input  logic [AW-1:0] ex_wd,
    input  logic [DW-1:0] ex_wdata,
    input  logic          mem_wreg,
    input  logic [AW-1:0] mem_wd,
    input  logic [DW-1:0] mem_wdata,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [DW-1:0] arr_data,
    output logic [DW-1:0] rdata
);

    fwd_src_e src;

    always_comb begin
        src = SRC_ARR;
        if (!rst) begin
            src = SRC_ZERO;
        end else if (re == ReadDisable) begin
            src = SRC_ZERO;
        end else if (raddr == '0) begin
            src = SRC_ZERO;
        end else if (ex_wreg && ex_wd == raddr) begin
            src = SRC_EX;
        end else if (mem_wreg && mem_wd == raddr) begin
            src = SRC_MEM;
        end else if (we && waddr == raddr) begin
            src = SRC_WB;
        end
    end

    always_comb begin
        rdata = '0;
        unique case (src)
            SRC_ZERO: rdata = '0;
            SRC_EX:   rdata = ex_wdata;
            SRC_MEM:  rdata = mem_wdata;
            SRC_WB:   rdata = wdata;
            SRC_ARR:  rdata = arr_data;
            default:  rdata = '0;
        endcase
    end

endmodule

// File: rtl/regfile_fwd.sv
// General-purpose register file with HI/LO and EX/MEM/WB operand bypass.
// Register 0 has no storage; both read ports share the bypass rules.
module regfile_fwd
    import regfile_fwd_pkg::*;
#(
    parameter int REG_NUM = RegNum,
    parameter int DATA_W  = RegDataW
) (
    input  logic          clk,
    input  logic          rst,
    regfile_fwd_if.slave  rf
);

    localparam int AW = $clog2(REG_NUM);

    logic [DATA_W-1:0] regs [1:REG_NUM-1];
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic [DATA_W-1:0] arr1;
    logic [DATA_W-1:0] arr2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else if (rf.we == WriteEnable && rf.waddr != '0) begin
            regs[rf.waddr] <= rf.wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi <= '0;
            lo <= '0;
        end else if (rf.hilo_we == WriteEnable) begin
            hi <= rf.hi_i;
            lo <= rf.lo_i;
        end
    end

    // Address 0 never indexes the array; the mux forces it to zero anyway.
    always_comb begin
        arr1 = '0;
        arr2 = '0;
        if (rf.raddr1 != '0) arr1 = regs[rf.raddr1];
        if (rf.raddr2 != '0) arr2 = regs[rf.raddr2];
    end

    regfile_fwd_mux #(.AW(AW), .DW(DATA_W)) u_mux1 (
        .rst       (rst),
        .re        (rf.re1),
        .raddr     (rf.raddr1),
        .ex_wreg   (rf.ex_wreg),
        .ex_wd     (rf.ex_wd),
        .ex_wdata  (rf.ex_wdata),
        .mem_wreg  (rf.mem_wreg),
        .mem_wd    (rf.mem_wd),
        .mem_wdata (rf.mem_wdata),
        .we        (rf.we),
        .waddr     (rf.waddr),
        .wdata     (rf.wdata),
        .arr_data  (arr1),
        .rdata     (rf.rdata1)
    );

    regfile_fwd_mux #(.AW(AW), .DW(DATA_W)) u_mux2 (
        .rst       (rst),
        .re        (rf.re2),
        .raddr     (rf.raddr2),
        .ex_wreg   (rf.ex_wreg),
        .ex_wd     (rf.ex_wd),
        .ex_wdata  (rf.ex_wdata),
        .mem_wreg  (rf.mem_wreg),
        .mem_wd    (rf.mem_wd),
        .mem_wdata (rf.mem_wdata),
        .we        (rf.we),
        .waddr     (rf.waddr),
        .wdata     (rf.wdata),
        .arr_data  (arr2),
        .rdata     (rf.rdata2)
    );

    assign rf.hi_o = !rst ? '0 : (rf.hilo_we ? rf.hi_i : hi);
    assign rf.lo_o = !rst ? '0 : (rf.hilo_we ? rf.lo_i : lo);

endmodule

// File: doc/regfile_fwd.md
# regfile_fwd

Architectural register file plus operand-forwarding network for the five-stage pipeline. It holds the 32 general-purpose registers and the HI/LO pair. It takes writes from the write-back stage and serves two read ports to the decode stage. Results still in flight in the execute stage and in the memory stage (the outputs of the EX/MEM pipeline register) are bypassed onto the read ports, so decode sees the newest value of every register without stalling.

## Interface
Parameters:
- REG_NUM, 32: number of general-purpose registers (address width log2(REG_NUM) = 5).
- DATA_W, 32: register width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- ex_wreg  in  1  execute-stage instruction writes a register.
- ex_wd  in  5  execute-stage destination address.
- ex_wdata  in  32  execute-stage result.
- mem_wreg  in  1  memory-stage write enable (EX/MEM register output).
- mem_wd  in  5  memory-stage destination address.
- mem_wdata  in  32  memory-stage result.
- we  in  1  write-back write enable.
- waddr  in  5  write-back address.
- wdata  in  32  write-back data.
- re1 / re2  in  1  read-port enables.
- raddr1 / raddr2  in  5  read addresses.
- rdata1 / rdata2  out  32  read data (combinational).
- hilo_we  in  1  write-back HI/LO write enable.
- hi_i / lo_i  in  32  write-back HI/LO data.
- hi_o / lo_o  out  32  current HI/LO, with write-back bypass.

## Operation
- Storage: regs[1..31], HI, LO. regs[0] is not stored; register 0 always reads 0.
- Write: on rising clk, if rst=1, we=1 and waddr≠0, then regs[waddr] ← wdata. If hilo_we=1, then HI ← hi_i and LO ← lo_i. A write with waddr=0 is discarded.
- Read port n (n = 1, 2), combinational priority, first match wins:
  - rst=0 → 0.
  - re_n=0 → 0.
  - raddr_n=0 → 0.
  - ex_wreg=1 and ex_wd=raddr_n → ex_wdata.
  - mem_wreg=1 and mem_wd=raddr_n → mem_wdata.
  - we=1 and waddr=raddr_n → wdata.
  - Otherwise → regs[raddr_n].
- HI/LO read: hilo_we=1 → hi_i/lo_i; otherwise the stored HI/LO. rst=0 → 0.
- Both ports resolve independently. The same address on both ports gives identical data.
- When EX and MEM target the same register, EX wins because it is the younger instruction.
- All forwarding compares are 5-bit equality. No partial-width merging.

## Timing
- Read latency: 0 cycles (combinational from every input).
- Write latency: 1 cycle. A value written at edge k is readable from the array after edge k. During the cycle before the edge it is visible through the write-back bypass.
- Reset: asserting rst=0 immediately clears regs[1..31], HI and LO to 0, independent of clk. All outputs read 0 while rst=0.
- Deasserting rst mid-operation takes effect only at the next clk edge. No write is taken on an edge where rst=0.
- Simultaneous write-back and read of the same address gives the new wdata, never the old value.
- No handshake and no stall output. Hazards on load-use are handled by the pipeline control block, not here.

## Structure
- Shared package/defines carry:
  - RegAddrBus, RegBus, ZeroWord, NOPRegAddr.
  - WriteEnable/WriteDisable and ReadEnable/ReadDisable.
  - RegNum.
- One natural sub-module: fwd_mux. It is the per-port priority selector, instantiated twice (rdata1, rdata2). The storage array and HI/LO stay in the top.

## Test plan
- Reset: load regs[5]=0x1234 and HI=0xAAAA, then pulse rst=0 mid-cycle. Required: rdata1 for raddr1=5 and hi_o read 0 immediately. After release they still read 0.
- Zero register: write-back we=1, waddr=0, wdata=0xFFFFFFFF; also ex_wreg=1, ex_wd=0. Required: raddr1=0 → rdata1=0, both during and after the edge.
- Write-then-read: we=1, waddr=7, wdata=0xDEADBEEF. Required: rdata1 for raddr1=7 reads 0xDEADBEEF in the same cycle via bypass, and again from the array after the edge.
- Forward priority: regs[3]=0x1, wb writes 3←0x2, mem_wd=3/0x3, ex_wd=3/0x4, all enabled. Required: rdata2=0x4. Drop ex_wreg → 0x3. Drop mem_wreg → 0x2.
- Dual port: raddr1=raddr2=9 with mem forwarding 0x55. Required: both ports read 0x55. Set re2=0 → rdata2=0 while rdata1 stays 0x55.
- HI/LO: hilo_we=1, hi_i=0x11, lo_i=0x22. Required: hi_o/lo_o = 0x11/0x22 in the same cycle. With hilo_we=0 the next cycle, the values are held.
